irq_controller: RTL

//  Interrupt source side of the CP0 exception interface. Collects device interrupt lines,

---
 rtl/irq_controller_if.sv | 25 ++
 rtl/irq_controller.sv | 99 +++++++++
 2 files changed

// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - config bus and coprocessor request/ack handshake for irq_controller
interface irq_controller_if #(
    parameter int ID_W = 3
);
    logic            cfg_we;
    logic [1:0]      cfg_addr;
    logic [7:0]      cfg_wdata;
    logic [7:0]      cfg_rdata;
    logic            int_req;
    logic [ID_W-1:0] int_id;
    logic            int_ack;
    logic            nmi_req;
    logic            nmi_ack;
    logic            eoi;

    modport master (
        input  cfg_we, cfg_addr, cfg_wdata, int_ack, nmi_ack, eoi,
        output cfg_rdata, int_req, int_id, nmi_req
    );

    modport slave (
        output cfg_we, cfg_addr, cfg_wdata, int_ack, nmi_ack, eoi,
        input  cfg_rdata, int_req, int_id, nmi_req
    );
endinterface

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - pending/mask/priority interrupt source for the CP0 exception interface
module irq_controller #(
    parameter int NUM_SRC = 6,
    parameter int ID_W    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               nmi_in,
    irq_controller_if.master   bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    logic [1:0]         state;
    logic [NUM_SRC-1:0] mask, pend, edge_sel, irq_prev;
    logic               nmi_prev, nmi_pend, nmi_req_r;
    logic [ID_W-1:0]    int_id_r;

    logic [NUM_SRC-1:0] active, id_sel, w1c, ack_clr, pend_next;
    logic [ID_W-1:0]    winner;
    logic               id_active, ack_take;
    logic [7:0]         status;

    always_comb begin
        active = pend & mask;
        winner = '0;
        // Descending scan so the lowest set index is written last and wins.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) winner = ID_W'(i);
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            id_sel[i] = (int_id_r == ID_W'(i));
        end
        id_active = |(active & id_sel);
        ack_take  = (state == S_REQ) && bus.int_ack;
        w1c       = (bus.cfg_we && bus.cfg_addr == 2'd1) ? bus.cfg_wdata[NUM_SRC-1:0] : '0;
        ack_clr   = ack_take ? id_sel : '0;
        // Edge sources: new edge beats any clear on the same cycle; level sources mirror the line.
        pend_next = (edge_sel & ((irq_in & ~irq_prev) | (pend & ~(w1c | ack_clr))))
                  | (~edge_sel & irq_in);
    end

    always_comb begin
        status            = '0;
        status[7:6]       = state;
        status[5]         = nmi_pend;
        status[ID_W-1:0]  = int_id_r;
        case (bus.cfg_addr)
            2'd0:    bus.cfg_rdata = 8'(mask);
            2'd1:    bus.cfg_rdata = 8'(pend);
            2'd2:    bus.cfg_rdata = 8'(edge_sel);
            default: bus.cfg_rdata = status;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mask      <= '0;
            pend      <= '0;
            edge_sel  <= '0;
            irq_prev  <= '0;
            nmi_prev  <= 1'b0;
            nmi_pend  <= 1'b0;
            nmi_req_r <= 1'b0;
            int_id_r  <= '0;
        end else begin
            irq_prev  <= irq_in;
            nmi_prev  <= nmi_in;
            pend      <= pend_next;
            nmi_pend  <= (nmi_in & ~nmi_prev) | (nmi_pend & ~bus.nmi_ack);
            nmi_req_r <= nmi_pend;
            if (bus.cfg_we && bus.cfg_addr == 2'd0) mask     <= bus.cfg_wdata[NUM_SRC-1:0];
            if (bus.cfg_we && bus.cfg_addr == 2'd2) edge_sel <= bus.cfg_wdata[NUM_SRC-1:0];
            case (state)
                S_IDLE: begin
                    if (|active) begin
                        state    <= S_REQ;
                        int_id_r <= winner;
                    end
                end
                S_REQ: begin
                    if (ack_take)        state <= S_SERVICE;
                    else if (!id_active) state <= S_IDLE;
                end
                S_SERVICE: begin
                    if (bus.eoi) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.int_req = (state == S_REQ);
    assign bus.int_id  = int_id_r;
    assign bus.nmi_req = nmi_req_r;
endmodule
